// File: rtl/pipe_arb_pkg.sv
// Shared types and helpers for the pipe input arbiter.
// Holds default widths, the message struct and the round-robin picker.
package pipe_arb_pkg;

   localparam int ARB_TAGW = 16;
   localparam int ARB_PAYW = 128;

   typedef struct packed {
      logic [ARB_TAGW-1:0] tag;
      logic [ARB_PAYW-1:0] payload;
   } pipe_msg_t;

   localparam int ARB_MSGW = $bits(pipe_msg_t);

   typedef struct packed {
      logic       vld;
      logic [2:0] idx;
   } rr_pick_t;

   // Rotate requests so ptr sits at bit 0, take the lowest set bit,
   // then map that position back to a requester index (n <= 8).
   function automatic rr_pick_t rr_pick(
      input logic [7:0] req,
      input logic [2:0] ptr,
      input int         n
   );
      rr_pick_t   r;
      logic [7:0] rot;
      int         first;
      r     = '0;
      rot   = '0;
      first = -1;
      for (int k = 0; k < 8; k++) begin
         if (k < n) rot[k] = req[3'((int'(ptr) + k) % n)];
      end
      for (int k = 7; k >= 0; k--) begin
         if (rot[k]) first = k;
      end
      if (first >= 0) begin
         r.vld = 1'b1;
         r.idx = 3'((int'(ptr) + first) % n);
      end
      return r;
   endfunction

endpackage

// File: rtl/pipe_arb_fifo.sv
// Small register FIFO holding granted messages until downstream takes them.
// Head reads as zero while empty so nothing stale leaks to the output.
module pipe_arb_fifo
   import pipe_arb_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int W     = ARB_MSGW
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          push_ok, pop_ok;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      push_ok = push && (cnt_q != CW'(DEPTH));
      pop_ok  = pop && (cnt_q != '0);
      mem_d   = mem_q;
      if (push_ok) mem_d[wr_q] = din;
      wr_d  = wr_q + AW'(push_ok);
      rd_d  = rd_q + AW'(pop_ok);
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
   end

   // State registers; reset discards everything queued.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Head of queue, forced to zero when empty.
   always_comb begin
      head  = (cnt_q == '0) ? '0 : mem_q[rd_q];
      count = cnt_q;
   end

endmodule

// File: rtl/pipe_in_arbiter.sv
// Round-robin share of one PipeIn request pipe among NREQ requesters.
// Optional per-requester accept counters: define PIPE_ARB_STATS_EN.
module pipe_in_arbiter
   import pipe_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int DEPTH = 2,
   parameter int TAGW  = ARB_TAGW,
   parameter int PAYW  = ARB_PAYW,
   localparam int W    = TAGW + PAYW
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [NREQ-1:0]   in_req,
   input  logic [NREQ-1:0]   in_enq__ENA,
   input  logic [NREQ*W-1:0] in_enq_v,
   output logic [NREQ-1:0]   in_enq__RDY,
   output logic              out_enq__ENA,
   output logic [W-1:0]      out_enq_v,
   input  logic              out_enq__RDY,
   output logic              arb_busy
`ifdef PIPE_ARB_STATS_EN
   ,
   input  logic              stat_clr,
   output logic [NREQ*16-1:0] stat_cnt
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [2:0]    rr_ptr_q, rr_ptr_d;
   logic [CW-1:0] cnt;
   logic [W-1:0]  head;
   logic [W-1:0]  push_data;
   logic          accept;
   rr_pick_t      pick;

   // Grant depends only on in_req, rr_ptr and occupancy; RDY drops
   // the instant reset asserts.
   always_comb begin
      pick = rr_pick(8'(in_req), rr_ptr_q, NREQ);
      for (int i = 0; i < NREQ; i++) begin
         in_enq__RDY[i] = nRST && pick.vld
                          && (pick.idx == 3'(i))
                          && (cnt < CW'(DEPTH));
      end
   end

   // Select the granted requester's message and advance the pointer
   // past the winner on an accept.
   always_comb begin
      accept    = |(in_enq__ENA & in_enq__RDY);
      push_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (in_enq__RDY[i]) push_data = in_enq_v[i*W +: W];
      end
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         rr_ptr_d = (pick.idx == 3'(NREQ-1)) ? 3'd0 : pick.idx + 3'd1;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) rr_ptr_q <= '0;
      else       rr_ptr_q <= rr_ptr_d;
   end

   pipe_arb_fifo #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_fifo (
      .CLK   (CLK),
      .nRST  (nRST),
      .push  (accept),
      .pop   (out_enq__ENA),
      .din   (push_data),
      .head  (head),
      .count (cnt)
   );

   // Downstream drain and busy flag.
   always_comb begin
      out_enq__ENA = (cnt != '0) && out_enq__RDY;
      out_enq_v    = head;
      arb_busy     = (cnt != '0);
   end

`ifdef PIPE_ARB_STATS_EN
   logic [15:0] stat_q [NREQ];
   logic [15:0] stat_d [NREQ];

   // Per-requester accept counters; clear beats a coincident accept.
   always_comb begin
      stat_d = stat_q;
      for (int i = 0; i < NREQ; i++) begin
         if (stat_clr)
            stat_d[i] = '0;
         else if (in_enq__ENA[i] && in_enq__RDY[i])
            stat_d[i] = stat_q[i] + 16'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   // Flatten counters onto the output bus.
   always_comb begin
      for (int i = 0; i < NREQ; i++) stat_cnt[i*16 +: 16] = stat_q[i];
   end
`endif

`ifdef PIPE_ARB_ASSERT
   // Strobes without a matching grant are dropped; flag them.
   always_ff @(posedge CLK) begin
      if (nRST) begin
         assert ((in_enq__ENA & ~in_enq__RDY) == '0)
            else $error("in_enq__ENA without in_enq__RDY: %b", in_enq__ENA);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_in_arbiter.sv
// Scoreboard bench for pipe_in_arbiter with directed vectors.
// Build with PIPE_ARB_STATS_EN to also cover the accept counters.
module tb_pipe_in_arbiter;
   import pipe_arb_pkg::*;

   localparam int NREQ  = 4;
   localparam int DEPTH = 2;
   localparam int W     = ARB_MSGW;

   logic              CLK;
   logic              nRST;
   logic [NREQ-1:0]   in_req;
   logic [NREQ-1:0]   ena;
   logic [NREQ*W-1:0] in_v;
   logic [NREQ-1:0]   rdy;
   logic              oena;
   logic [W-1:0]      ov;
   logic              ordy;
   logic              busy;
`ifdef PIPE_ARB_STATS_EN
   logic              stat_clr;
   logic [NREQ*16-1:0] stat_cnt;
`endif

   pipe_in_arbiter #(
      .NREQ  (NREQ),
      .DEPTH (DEPTH)
   ) dut (
      .CLK          (CLK),
      .nRST         (nRST),
      .in_req       (in_req),
      .in_enq__ENA  (ena),
      .in_enq_v     (in_v),
      .in_enq__RDY  (rdy),
      .out_enq__ENA (oena),
      .out_enq_v    (ov),
      .out_enq__RDY (ordy),
      .arb_busy     (busy)
`ifdef PIPE_ARB_STATS_EN
      ,
      .stat_clr     (stat_clr),
      .stat_cnt     (stat_cnt)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int n_chk  = 0;
   int n_pass = 0;
   int seed   = 0;
   logic [W-1:0] sb[$];

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   function automatic logic [W-1:0] mk(input int i, input int s);
      pipe_msg_t m;
      m.tag     = 16'(i + 1);
      m.payload = {8{16'hA5A5}} ^ 128'(s);
      return m;
   endfunction

   // Monitor: every output strobe must match the oldest expected entry.
   always @(negedge CLK) begin
      if (nRST && oena) begin
         if (sb.size() == 0) begin
            chk("unexpected_out", ov, '0);
            if (ov == '0) $display("FAIL unexpected_out: strobe with empty scoreboard");
         end else begin
            chk("out_msg", ov, sb.pop_front());
         end
      end
   end

   task automatic step(input logic [3:0] req, input logic [3:0] en,
                       input logic [3:0] xrdy, input logic o_rdy,
                       input logic xbusy, input logic xoena);
      @(posedge CLK);
      #1;
      seed++;
      in_req = req;
      ena    = en;
      ordy   = o_rdy;
      for (int i = 0; i < NREQ; i++) in_v[i*W +: W] = mk(i, seed);
      #1;
      chk("grant", W'(rdy), W'(xrdy));
      chk("busy", W'(busy), W'(xbusy));
      chk("out_ena", W'(oena), W'(xoena));
      for (int i = 0; i < NREQ; i++)
         if (en[i] && xrdy[i]) sb.push_back(mk(i, seed));
   endtask

   initial begin
      logic [3:0] oh;
      nRST   = 1'b0;
      in_req = 4'b1111;
      ena    = '0;
      in_v   = '0;
      ordy   = 1'b1;
`ifdef PIPE_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      #3;
      chk("rst_rdy", W'(rdy), '0);
      chk("rst_oena", W'(oena), '0);
      chk("rst_ov", ov, '0);
      chk("rst_busy", W'(busy), '0);
`ifdef PIPE_ARB_STATS_EN
      chk("rst_stat", W'(stat_cnt), '0);
`endif
      repeat (2) @(negedge CLK);
      nRST   = 1'b1;
      in_req = '0;

      // single source, one-cycle latency
      step(4'b0001, 4'b0001, 4'b0001, 1, 0, 0);
      step(4'b0000, 4'b0000, 4'b0000, 1, 1, 1);
      step(4'b0000, 4'b0000, 4'b0000, 1, 0, 0);

      // all requesting: rotation from rr_ptr=1
      step(4'b1111, 4'b0010, 4'b0010, 1, 0, 0);
      step(4'b1111, 4'b0100, 4'b0100, 1, 1, 1);
      step(4'b1111, 4'b1000, 4'b1000, 1, 1, 1);
      step(4'b1111, 4'b0001, 4'b0001, 1, 1, 1);
      step(4'b1111, 4'b0010, 4'b0010, 1, 1, 1);
      step(4'b0000, 4'b0000, 4'b0000, 1, 1, 1);

      // backpressure to full, then one drain reopens the grant
      step(4'b1111, 4'b0100, 4'b0100, 0, 0, 0);
      step(4'b1111, 4'b1000, 4'b1000, 0, 1, 0);
      step(4'b1111, 4'b0000, 4'b0000, 0, 1, 0);
      step(4'b1111, 4'b0000, 4'b0000, 1, 1, 1);
      step(4'b1111, 4'b0001, 4'b0001, 1, 1, 1);
      step(4'b0000, 4'b0000, 4'b0000, 1, 1, 1);
      step(4'b0000, 4'b0000, 4'b0000, 1, 0, 0);

      // concurrent push/pop at count 1
      step(4'b0010, 4'b0010, 4'b0010, 1, 0, 0);
      for (int k = 0; k < 10; k++) begin
         oh = 4'b0001 << ((2 + k) % 4);
         step(4'b1111, oh, oh, 1, 1, 1);
      end
      step(4'b0000, 4'b0000, 4'b0000, 1, 1, 1);
      step(4'b0000, 4'b0000, 4'b0000, 1, 0, 0);

      // reset with two queued
      step(4'b1111, 4'b0001, 4'b0001, 0, 0, 0);
      step(4'b1111, 4'b0010, 4'b0010, 0, 1, 0);
      @(posedge CLK);
      #1;
      in_req = 4'b1111;
      ena    = '0;
      ordy   = 1'b1;
      #2;
      nRST = 1'b0;
      #1;
      chk("mid_rst_rdy", W'(rdy), '0);
      chk("mid_rst_oena", W'(oena), '0);
      chk("mid_rst_ov", ov, '0);
      chk("mid_rst_busy", W'(busy), '0);
      sb.delete();
      repeat (2) @(negedge CLK);
      nRST = 1'b1;
      step(4'b0000, 4'b0000, 4'b0000, 1, 0, 0);
      step(4'b0000, 4'b0000, 4'b0000, 1, 0, 0);
      step(4'b1111, 4'b0001, 4'b0001, 1, 0, 0);
      step(4'b0000, 4'b0000, 4'b0000, 1, 1, 1);
      step(4'b0000, 4'b0000, 4'b0000, 1, 0, 0);

`ifdef PIPE_ARB_STATS_EN
      stat_clr = 1'b1;
      step(4'b0000, 4'b0000, 4'b0000, 1, 0, 0);
      stat_clr = 1'b0;
      for (int k = 0; k < 5; k++)
         step(4'b0100, 4'b0100, 4'b0100, 1, k != 0, k != 0);
      for (int k = 0; k < 3; k++)
         step(4'b0001, 4'b0001, 4'b0001, 1, 1, 1);
      step(4'b0000, 4'b0000, 4'b0000, 1, 1, 1);
      chk("stat_req2", W'(stat_cnt[32 +: 16]), W'(16'd5));
      chk("stat_req0", W'(stat_cnt[0 +: 16]), W'(16'd3));
      step(4'b0001, 4'b0001, 4'b0001, 1, 0, 0);
      stat_clr = 1'b1;
      step(4'b0000, 4'b0000, 4'b0000, 1, 1, 1);
      stat_clr = 1'b0;
      chk("stat_clr_wins", W'(stat_cnt), '0);
      step(4'b0000, 4'b0000, 4'b0000, 1, 0, 0);
`endif

      @(posedge CLK);
      #1;
      chk("sb_drained", W'(sb.size()), '0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
